uart_byte_receiver: RTL and testbench
=====================================

Name: uart_byte_receiver

Overview:
- Asynchronous serial receiver (8 data bits, no parity, 1 stop bit, LSB first) that turns a line-level RX input into parallel bytes.
- It is the receive end of the serial link driven by the team's terminal/serial writer models and the GFX controller's serial TX path.
- It sits behind the board's serial RX pin and presents each byte to the command logic through a valid/acknowledge holding register.
- It reports framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 217: CLK cycles per bit period (25 MHz / 115200). Legal range is 8..65535.
- SYNC_STAGES, 2: flip-flops in the RX metastability synchroniser. Legal range is 2..4.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous active-high reset.
- RX  input  1  asynchronous serial line; idles high.
- DATA  output  8  last received byte; stable while VALID=1.
- VALID  output  1  a byte is held in DATA; cleared by ACK.
- ACK  input  1  consumer takes the byte; sampled only while VALID=1.
- FRAME_ERR  output  1  sticky: a stop bit was sampled low; cleared by ACK or RST.
- OVERRUN  output  1  sticky: a byte completed while VALID=1; cleared by ACK or RST.
- BUSY  output  1  a frame is in progress (state other than IDLE).

Behaviour:
- Reset (RST=1 at a CLK edge) applies to everything. DATA=0, VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0, FSM=IDLE, counters=0, synchroniser chain=all 1s. RST mid-frame abandons the frame with no VALID pulse.
- RX passes through the SYNC_STAGES flop chain; the result is rxs. All decisions use rxs.
- Bit counter: a clock counter, width ceil(log2(CLKS_PER_BIT)). Mid-bit is the count CLKS_PER_BIT/2, using integer division.
- FSM states:
  - IDLE: on rxs falling (previous 1, current 0), go to START and clear the counter.
  - START: at mid-bit, if rxs=0, go to DATA, clear the counter and set bit index=0. If rxs=1, treat it as a glitch and return to IDLE with no flags.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into shift[bit index], LSB first. After bit index 7, go to STOP.
  - STOP: at the stop-bit centre, go to DONE. If rxs=0, set FRAME_ERR. The byte is still delivered.
  - DONE: lasts exactly one cycle and delivers the byte (see below), then goes to IDLE. If rxs=0 here, wait in IDLE for rxs=1 before arming the falling-edge detector, so a break does not retrigger.
- Delivery in DONE:
  - If VALID=0, DATA<=shift and VALID<=1.
  - If VALID=1 and ACK is not asserted this cycle, DATA is kept (the new byte is dropped) and OVERRUN<=1.
  - If VALID=1 and ACK=1 in the same cycle, the ACK consumes the old byte. The new byte is loaded, VALID stays 1, and OVERRUN is not set.
- ACK when VALID=1 and there is no simultaneous DONE: next cycle VALID=0, FRAME_ERR=0, OVERRUN=0.
- ACK when VALID=0 is ignored.
- Latency: VALID rises 1 cycle after the stop-bit centre sample. Measured from the start-edge detection in rxs, that is CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 cycles.
- BUSY=1 in START, DATA, STOP and DONE.
- Back-to-back frames are supported: the next start edge is accepted immediately after DONE.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- When defined, each start, data and stop bit decision is a 2-of-3 majority of rxs sampled at mid-2, mid and mid+2. This gives noise immunity; the decision is committed at mid+2, adding 2 cycles to the latency.
- When undefined, the decision is a single sample at mid-bit.
- The port list is identical either way.

Test Plan:
- Single byte, CLKS_PER_BIT=16: drive RX frame 0xA5 with a good stop bit -> DATA=0xA5, VALID=1 at the computed latency, FRAME_ERR=0, OVERRUN=0. Then ACK -> VALID=0 the next cycle.
- Glitch rejection: RX low for 5 cycles, then high -> the FSM returns to IDLE, VALID stays 0, BUSY high for at most 8 cycles.
- Framing error: send 0x3C with the stop bit held low -> DATA=0x3C, VALID=1, FRAME_ERR=1. With RX kept low, no new frame starts until RX returns high. ACK clears both flags.
- Overrun: send 0x11 and 0x22 back-to-back without ACK -> DATA=0x11, OVERRUN=1. Repeat with ACK asserted exactly in the DONE cycle of 0x22 -> DATA=0x22, VALID=1, OVERRUN=0.
- Reset mid-frame: assert RST during bit 4 of 0xFF -> all outputs 0 next cycle. A following 0x5A frame is received correctly.
- With UART_RX_MAJORITY_EN: inject a 1-cycle inverted pulse at the mid-bit of each data bit of 0x81 -> DATA=0x81. The same stimulus without the macro -> DATA=0x7E.

Source files
------------

// File: rtl/uart_byte_receiver.sv
// 8N1 serial receiver with metastability synchroniser and a valid/ack holding register.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote per bit around the bit centre.
module uart_byte_receiver #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       ACK,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned MAJ_OFF = 2;
`else
    localparam int unsigned MAJ_OFF = 0;
`endif
    // The start-detection cycle counts as bit-time 0, so the start centre is reached at MID-1.
    localparam logic [CW-1:0] START_DEC = CW'(CLKS_PER_BIT / 2 - 1 + MAJ_OFF);
    localparam logic [CW-1:0] BIT_DEC   = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_prev;
    state_e                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_idx;
    logic [7:0]             r_shift;
    logic                   r_stop_err;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_fe;
    logic                   r_ovr;

    state_e        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_stop_err_nxt;
    logic          w_rxs;
    logic [CW-1:0] w_dec_cnt;
    logic          w_decide;
    logic          w_bit;

    assign w_rxs     = r_sync[SYNC_STAGES-1];
    assign w_dec_cnt = (r_state == StStart) ? START_DEC : BIT_DEC;
    assign w_decide  = (r_cnt == w_dec_cnt);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_maj;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_maj <= 2'b11;
        end else begin
            if (r_cnt == w_dec_cnt - CW'(4)) r_maj[0] <= w_rxs;
            if (r_cnt == w_dec_cnt - CW'(2)) r_maj[1] <= w_rxs;
        end
    end

    assign w_bit = (r_maj[0] & r_maj[1]) | (r_maj[0] & w_rxs) | (r_maj[1] & w_rxs);
`else
    assign w_bit = w_rxs;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + CW'(1);
        w_idx_nxt      = r_idx;
        w_shift_nxt    = r_shift;
        w_stop_err_nxt = r_stop_err;
        unique case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                // Edge-based arming: a line held low after a frame cannot retrigger.
                if (r_rxs_prev && !w_rxs) w_state_nxt = StStart;
            end
            StStart: begin
                if (w_decide) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = w_bit ? StIdle : StData;
                end
            end
            StData: begin
                if (w_decide) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_bit;
                    w_idx_nxt          = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state_nxt = StStop;
                end
            end
            StStop: begin
                if (w_decide) begin
                    w_cnt_nxt      = '0;
                    w_stop_err_nxt = !w_bit;
                    w_state_nxt    = StDone;
                end
            end
            StDone: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync     <= '1;
            r_rxs_prev <= 1'b1;
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            r_shift    <= 8'h00;
            r_stop_err <= 1'b0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_fe       <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], RX};
            r_rxs_prev <= w_rxs;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_stop_err <= w_stop_err_nxt;
            if (r_state == StDone) begin
                // A same-cycle ACK retires the old byte and its flags before the new one lands.
                if (!r_valid || ACK) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                    r_ovr   <= 1'b0;
                    r_fe    <= (r_fe & !r_valid) | r_stop_err;
                end else begin
                    r_ovr <= 1'b1;
                    r_fe  <= r_fe | r_stop_err;
                end
            end else if (r_valid && ACK) begin
                r_valid <= 1'b0;
                r_fe    <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign DATA      = r_data;
    assign VALID     = r_valid;
    assign FRAME_ERR = r_fe;
    assign OVERRUN   = r_ovr;
    assign BUSY      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 16 clocks per bit, 2-stage synchroniser.
`timescale 1ns/1ps
module tb_uart_byte_receiver;

    localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 2;
    localparam logic [7:0] PULSE_EXP = 8'h81;
`else
    localparam int MAJ = 0;
    localparam logic [7:0] PULSE_EXP = 8'h7E;
`endif
    // Edges from driving the start bit to VALID: 2 sync + 1 detect + CPB/2 + 9*CPB + 1.
    localparam int LAT = 2 + 1 + CPB / 2 + 9 * CPB + 1 + MAJ;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX  = 1'b1;
    logic       ACK = 1'b0;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    int n_pass  = 0;
    int n_total = 0;
    int v_rise  = -1;
    int cnt     = 0;

    uart_byte_receiver #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX       (RX),
        .DATA     (DATA),
        .VALID    (VALID),
        .ACK      (ACK),
        .FRAME_ERR(FRAME_ERR),
        .OVERRUN  (OVERRUN),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic do_ack();
        ACK = 1'b1;
        @(negedge CLK);
        ACK = 1'b0;
    endtask

    // Sends one frame; optional 1-cycle inverted pulse at each data bit's centre sample and
    // optional ACK sampled on the edge after edge number ack_cyc.
    task automatic send(input logic [7:0] d, input logic stop, input bit pulse, input int ack_cyc);
        logic [9:0] fr;
        logic       vp;
        int         c;
        fr     = {stop, d, 1'b0};
        vp     = VALID;
        c      = 0;
        v_rise = -1;
        for (int b = 0; b < 10; b++) begin
            RX = fr[b];
            for (int k = 0; k < CPB; k++) begin
                if (pulse && b >= 1 && b <= 8 && k == 8) RX = ~fr[b];
                if (pulse && b >= 1 && b <= 8 && k == 9) RX = fr[b];
                ACK = (c == ack_cyc);
                @(negedge CLK);
                c++;
                if (VALID && !vp && v_rise < 0) v_rise = c;
                vp = VALID;
            end
        end
        ACK = 1'b0;
    endtask

    initial begin
        idle(3);
        check("rst_data", DATA, 8'h00);
        check("rst_valid", VALID, 1'b0);
        check("rst_fe", FRAME_ERR, 1'b0);
        check("rst_ovr", OVERRUN, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        RST = 1'b0;
        idle(10);

        // Single byte with latency
        send(8'hA5, 1'b1, 1'b0, -1);
        check("a5_latency", v_rise, LAT);
        check("a5_data", DATA, 8'hA5);
        check("a5_valid", VALID, 1'b1);
        check("a5_fe", FRAME_ERR, 1'b0);
        check("a5_ovr", OVERRUN, 1'b0);
        do_ack();
        check("a5_ack_valid", VALID, 1'b0);
        idle(20);

        // Glitch rejection
        cnt = 0;
        RX  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (i == 4) RX = 1'b1;
            if (BUSY) cnt++;
        end
        check("glitch_busy_cycles", cnt, 8 + MAJ);
        check("glitch_valid", VALID, 1'b0);
        check("glitch_busy_end", BUSY, 1'b0);
        idle(10);

        // Framing error with a held-low line
        send(8'h3C, 1'b0, 1'b0, -1);
        check("fe_data", DATA, 8'h3C);
        check("fe_valid", VALID, 1'b1);
        check("fe_flag", FRAME_ERR, 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (BUSY) cnt++;
        end
        check("fe_break_no_start", cnt, 0);
        RX = 1'b1;
        idle(10);
        check("fe_still_set", FRAME_ERR, 1'b1);
        do_ack();
        check("fe_ack_valid", VALID, 1'b0);
        check("fe_ack_flag", FRAME_ERR, 1'b0);
        idle(20);

        // Overrun without ACK
        send(8'h11, 1'b1, 1'b0, -1);
        send(8'h22, 1'b1, 1'b0, -1);
        check("ovr_data", DATA, 8'h11);
        check("ovr_valid", VALID, 1'b1);
        check("ovr_flag", OVERRUN, 1'b1);
        do_ack();
        check("ovr_ack_valid", VALID, 1'b0);
        check("ovr_ack_flag", OVERRUN, 1'b0);
        idle(20);

        // ACK exactly in the DONE cycle of the second byte
        send(8'h11, 1'b1, 1'b0, -1);
        send(8'h22, 1'b1, 1'b0, LAT - 1);
        check("ackdone_data", DATA, 8'h22);
        check("ackdone_valid", VALID, 1'b1);
        check("ackdone_ovr", OVERRUN, 1'b0);
        idle(5);

        // Reset during bit 4 of 0xFF, with 0x22 still held
        RX = 1'b0;
        idle(CPB);
        RX = 1'b1;
        idle(4 * CPB + CPB / 2);
        check("mid_busy_before", BUSY, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_data", DATA, 8'h00);
        check("midrst_valid", VALID, 1'b0);
        check("midrst_fe", FRAME_ERR, 1'b0);
        check("midrst_ovr", OVERRUN, 1'b0);
        check("midrst_busy", BUSY, 1'b0);
        idle(6 * CPB);
        check("midrst_no_valid", VALID, 1'b0);
        send(8'h5A, 1'b1, 1'b0, -1);
        check("post_rst_data", DATA, 8'h5A);
        check("post_rst_valid", VALID, 1'b1);
        check("post_rst_fe", FRAME_ERR, 1'b0);
        do_ack();
        idle(20);

        // Centre-sample noise pulses on 0x81
        send(8'h81, 1'b1, 1'b1, -1);
        check("pulse_data", DATA, PULSE_EXP);
        check("pulse_valid", VALID, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
